// File: rtl/hw_int_ctrl.sv
// Interrupt controller driving CP0 HWint[7:2]: edge/level pending, mask, fixed priority, ack holdoff.
// Optional define INT_SYNC_EN inserts a 2-flop synchronizer on every dev_irq line.
module hw_int_ctrl #(
   parameter int unsigned HOLDOFF = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  dev_irq,
   input  logic        int_ack,
   input  logic        reg_we,
   input  logic [1:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic [5:0]  HWint,
   output logic        irq_busy
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAssert = 2'd1,
      StHold   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  hwint_q, hwint_d;
   logic [5:0]  mode_q, enable_q, pend_q, pend_d, prev_q;
   logic [5:0]  s, elig, edge_set, w1c, ack_clr;
   logic        ack_fire;
   logic        unused_wdata;

   assign unused_wdata = ^reg_wdata[31:6];

`ifdef INT_SYNC_EN
   logic [5:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= dev_irq;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = dev_irq;
`endif

   function automatic logic [2:0] prio(input logic [5:0] v);
      prio = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (v[i]) prio = 3'(i);
      end
   endfunction

   assign elig     = pend_q & enable_q;
   assign ack_fire = (state_q == StAssert) && int_ack;
   assign w1c      = (reg_we && reg_addr == 2'd2) ? reg_wdata[5:0] : 6'd0;
   assign ack_clr  = ack_fire ? (6'd1 << sel_q) : 6'd0;
   assign edge_set = s & ~prev_q;

   // Level bits track the input; edge bits hold until cleared, and a new edge beats a clear.
   assign pend_d = (~mode_q & s) | (mode_q & (edge_set | (pend_q & ~(w1c | ack_clr))));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      hwint_d = hwint_q;
      case (state_q)
         StIdle: begin
            if (|elig) begin
               sel_d   = prio(elig);
               hwint_d = 6'd1 << prio(elig);
               state_d = StAssert;
            end
         end
         StAssert: begin
            if (int_ack) begin
               hwint_d = '0;
               cnt_d   = 4'(HOLDOFF);
               state_d = StHold;
            end else if (!elig[sel_q]) begin
               hwint_d = '0;
               state_d = StIdle;
            end
         end
         StHold: begin
            // The last holdoff cycle also makes the idle decision, so HWint stays low
            // for exactly HOLDOFF cycles after an ack.
            if (cnt_q == 4'd1) begin
               if (|elig) begin
                  sel_d   = prio(elig);
                  hwint_d = 6'd1 << prio(elig);
                  state_d = StAssert;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            hwint_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         cnt_q    <= '0;
         hwint_q  <= '0;
         mode_q   <= '0;
         enable_q <= 6'h3f;
         pend_q   <= '0;
         prev_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         hwint_q <= hwint_d;
         pend_q  <= pend_d;
         prev_q  <= s;
         if (reg_we && reg_addr == 2'd0) mode_q <= reg_wdata[5:0];
         if (reg_we && reg_addr == 2'd1) enable_q <= reg_wdata[5:0];
      end
   end

   assign HWint    = hwint_q;
   assign irq_busy = (state_q != StIdle);

   always_comb begin
      reg_rdata = '0;
      unique case (reg_addr)
         2'd0: reg_rdata = {26'd0, mode_q};
         2'd1: reg_rdata = {26'd0, enable_q};
         2'd2: reg_rdata = {26'd0, pend_q};
         2'd3: reg_rdata = {24'd0, state_q, 1'b0, sel_q, |hwint_q, irq_busy};
      endcase
   end

endmodule

// File: tb/tb_hw_int_ctrl.sv
// Self-checking bench for hw_int_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_hw_int_ctrl;

   localparam int unsigned HOLDOFF = 2;
`ifdef INT_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic        clk;
   logic        reset;
   logic [5:0]  dev_irq;
   logic        int_ack;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic [5:0]  HWint;
   logic        irq_busy;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   logic [5:0] m_mode, m_en, m_pend, m_prev, m_hw, m_s1, m_s2;
   int         m_phase;  // 0 idle, 1 presenting, 2 holdoff
   int         m_sel;
   int         m_left;

   hw_int_ctrl #(.HOLDOFF(HOLDOFF)) dut (
      .clk       (clk),
      .reset     (reset),
      .dev_irq   (dev_irq),
      .int_ack   (int_ack),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .HWint     (HWint),
      .irq_busy  (irq_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_pick(input logic [5:0] e);
      int top;
      top = -1;
      for (int i = 0; i < 6; i++) if (e[i]) top = i;
      if (top >= 0) begin
         m_sel   = top;
         m_hw    = 6'(1 << top);
         m_phase = 1;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic model_step(input logic [5:0] dev, input logic ack, input logic we,
                             input logic [1:0] addr, input logic [31:0] wd, input logic rst);
      logic [5:0] s, e, np;
      if (rst) begin
         m_mode = 0; m_en = 6'h3f; m_pend = 0; m_prev = 0; m_hw = 0;
         m_s1 = 0; m_s2 = 0; m_phase = 0; m_sel = 0; m_left = 0;
         return;
      end
`ifdef INT_SYNC_EN
      s = m_s2;
`else
      s = dev;
`endif
      e  = m_pend & m_en;
      np = m_pend;
      for (int i = 0; i < 6; i++) begin
         if (!m_mode[i]) np[i] = s[i];
         else if (s[i] && !m_prev[i]) np[i] = 1'b1;
         else if ((m_phase == 1 && ack && m_sel == i) || (we && addr == 2'd2 && wd[i]))
            np[i] = 1'b0;
      end
      case (m_phase)
         0: model_pick(e);
         1: begin
            if (ack) begin
               m_hw = 0; m_left = HOLDOFF; m_phase = 2;
            end else if (!e[m_sel]) begin
               m_hw = 0; m_phase = 0;
            end
         end
         default: begin
            if (m_left == 1) model_pick(e);
            else m_left = m_left - 1;
         end
      endcase
      if (we && addr == 2'd0) m_mode = wd[5:0];
      if (we && addr == 2'd1) m_en = wd[5:0];
      m_pend = np;
      m_prev = s;
      m_s2   = m_s1;
      m_s1   = dev;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0: return {26'd0, m_mode};
         2'd1: return {26'd0, m_en};
         2'd2: return {26'd0, m_pend};
         default: return {24'd0, 2'(m_phase), 1'b0, 3'(m_sel), |m_hw, m_phase != 0};
      endcase
   endfunction

   task automatic tick(input logic [5:0] dev, input logic ack, input logic we,
                       input logic [1:0] addr, input logic [31:0] wd, input logic rst);
      dev_irq   = dev;
      int_ack   = ack;
      reg_we    = we;
      reg_addr  = addr;
      reg_wdata = wd;
      reset     = rst;
      model_step(dev, ack, we, addr, wd, rst);
      @(posedge clk);
      #1;
      int_ack = 1'b0;
      reg_we  = 1'b0;
      reset   = 1'b0;
   endtask

   task automatic idle(input logic [5:0] dev);
      tick(dev, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      reg_addr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      n_cmp++;
      if (HWint !== 6'h00) begin
         n_fail++; $display("FAIL reset_hwint: got %h want 00", HWint);
      end
      n_cmp++;
      if (irq_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", irq_busy);
      end
      rd(2'd0, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL reset_mode: got %h want 0", d);
      end
      rd(2'd1, d);
      n_cmp++;
      if (d !== 32'h3f) begin
         n_fail++; $display("FAIL reset_enable: got %h want 3f", d);
      end
      rd(2'd2, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL reset_pending: got %h want 0", d);
      end
      rd(2'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL reset_status: got %h want 0", d);
      end
   endtask

   task automatic test_level_basic();
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      idle(6'h04);
      repeat (SL) idle(6'h04);
      n_cmp++;
      if (HWint !== 6'h00) begin
         n_fail++; $display("FAIL level_early: got %h want 00", HWint);
      end
      idle(6'h04);
      n_cmp++;
      if (HWint !== 6'h04) begin
         n_fail++; $display("FAIL level_assert: got %h want 04", HWint);
      end
      tick(6'h04, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      n_cmp++;
      if (HWint !== 6'h00 || irq_busy !== 1'b1) begin
         n_fail++; $display("FAIL level_hold1: got %h/%b want 00/1", HWint, irq_busy);
      end
      idle(6'h04);
      n_cmp++;
      if (HWint !== 6'h00) begin
         n_fail++; $display("FAIL level_hold2: got %h want 00", HWint);
      end
      idle(6'h04);
      n_cmp++;
      if (HWint !== 6'h04) begin
         n_fail++; $display("FAIL level_reassert: got %h want 04", HWint);
      end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      tick(6'h00, 1'b0, 1'b1, 2'd0, 32'h3f, 1'b0);
      idle(6'h12);
      idle(6'h00);
      repeat (SL) idle(6'h00);
      n_cmp++;
      if (HWint !== 6'h10) begin
         n_fail++; $display("FAIL prio_first: got %h want 10", HWint);
      end
      tick(6'h00, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      idle(6'h00);
      idle(6'h00);
      n_cmp++;
      if (HWint !== 6'h02) begin
         n_fail++; $display("FAIL prio_second: got %h want 02", HWint);
      end
      tick(6'h00, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      rd(2'd2, d);
      n_cmp++;
      if (d !== 32'h0 || HWint !== 6'h00) begin
         n_fail++; $display("FAIL prio_drained: got pend %h hw %h want 0/00", d, HWint);
      end
   endtask

   task automatic test_w1c_withdraw();
      logic [31:0] d;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      tick(6'h00, 1'b0, 1'b1, 2'd0, 32'h3f, 1'b0);
      idle(6'h08);
      idle(6'h00);
      repeat (SL) idle(6'h00);
      n_cmp++;
      if (HWint !== 6'h08) begin
         n_fail++; $display("FAIL w1c_assert: got %h want 08", HWint);
      end
      tick(6'h00, 1'b0, 1'b1, 2'd2, 32'h08, 1'b0);
      n_cmp++;
      if (HWint !== 6'h08) begin
         n_fail++; $display("FAIL w1c_same_cycle: got %h want 08", HWint);
      end
      idle(6'h00);
      rd(2'd3, d);
      n_cmp++;
      if (HWint !== 6'h00 || d[7:6] !== 2'd0 || irq_busy !== 1'b0) begin
         n_fail++; $display("FAIL w1c_withdrawn: got hw %h st %h want 00/idle", HWint, d);
      end
   endtask

   task automatic test_enable_mask();
      logic [31:0] d;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      tick(6'h00, 1'b0, 1'b1, 2'd1, 32'h1f, 1'b0);
      repeat (3 + SL) idle(6'h20);
      rd(2'd2, d);
      n_cmp++;
      if (HWint !== 6'h00 || d !== 32'h20) begin
         n_fail++; $display("FAIL mask_hold: got hw %h pend %h want 00/20", HWint, d);
      end
      tick(6'h20, 1'b0, 1'b1, 2'd1, 32'h3f, 1'b0);
      idle(6'h20);
      n_cmp++;
      if (HWint !== 6'h20) begin
         n_fail++; $display("FAIL mask_unmask: got %h want 20", HWint);
      end
   endtask

   task automatic test_ack_collision();
`ifndef INT_SYNC_EN
      logic [31:0] d;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      tick(6'h00, 1'b0, 1'b1, 2'd0, 32'h3f, 1'b0);
      idle(6'h01);
      idle(6'h00);
      n_cmp++;
      if (HWint !== 6'h01) begin
         n_fail++; $display("FAIL coll_assert: got %h want 01", HWint);
      end
      tick(6'h01, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      rd(2'd2, d);
      n_cmp++;
      if (d !== 32'h1 || HWint !== 6'h00) begin
         n_fail++; $display("FAIL coll_set_wins: got pend %h hw %h want 1/00", d, HWint);
      end
      idle(6'h00);
      idle(6'h00);
      n_cmp++;
      if (HWint !== 6'h01) begin
         n_fail++; $display("FAIL coll_represent: got %h want 01", HWint);
      end
`endif
   endtask

   task automatic test_reset_in_hold();
      logic [31:0] d, p;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      tick(6'h00, 1'b0, 1'b1, 2'd0, 32'h3f, 1'b0);
      idle(6'h04);
      idle(6'h20);
      repeat (SL) idle(6'h20);
      n_cmp++;
      if (HWint !== 6'h04) begin
         n_fail++; $display("FAIL rsthold_assert: got %h want 04", HWint);
      end
      tick(6'h20, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      rd(2'd3, d);
      rd(2'd2, p);
      n_cmp++;
      if (d[7:6] !== 2'd2 || p !== 32'h20) begin
         n_fail++; $display("FAIL rsthold_in_hold: got st %h pend %h want hold/20", d, p);
      end
      tick(6'h20, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      rd(2'd3, d);
      rd(2'd2, p);
      n_cmp++;
      if (HWint !== 6'h00 || p !== 32'h0 || d !== 32'h0) begin
         n_fail++; $display("FAIL rsthold_cleared: got hw %h pend %h st %h want 0", HWint, p, d);
      end
   endtask

   task automatic test_random();
      logic [5:0]  dev;
      logic [1:0]  a;
      logic [31:0] d;
      dev = 6'h00;
      tick(6'h00, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(3) == 0) dev = dev ^ 6'($urandom);
         tick(dev, $urandom_range(2) == 0, $urandom_range(7) == 0, 2'($urandom),
              $urandom, $urandom_range(199) == 0);
         n_cmp++;
         if (HWint !== m_hw) begin
            n_fail++; $display("FAIL rand_hwint @%0d: got %h want %h", n, HWint, m_hw);
         end
         n_cmp++;
         if (irq_busy !== (m_phase != 0)) begin
            n_fail++; $display("FAIL rand_busy @%0d: got %b want %b", n, irq_busy, m_phase != 0);
         end
         a = 2'($urandom);
         rd(a, d);
         n_cmp++;
         if (d !== model_read(a)) begin
            n_fail++; $display("FAIL rand_read%0d @%0d: got %h want %h", a, n, d, model_read(a));
         end
      end
   endtask

   initial begin
      dev_irq   = '0;
      int_ack   = 1'b0;
      reg_we    = 1'b0;
      reg_addr  = '0;
      reg_wdata = '0;
      reset     = 1'b1;
      test_reset();
      test_level_basic();
      test_priority();
      test_w1c_withdraw();
      test_enable_mask();
      test_ack_collision();
      test_reset_in_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
